// File: rtl/mouse_move_accum.sv
// Integrates per-direction step pulses into saturating signed X/Y deltas and issues
// valid/ready movement reports. Optional scroll wheel (Z axis) enabled by WHEEL_EN.
module mouse_move_accum #(
    parameter int DELTA_W = 8,
    parameter int STEP    = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_pulse_up,
    input  logic               i_pulse_down,
    input  logic               i_pulse_left,
    input  logic               i_pulse_right,
    input  logic               i_btn_left,
    input  logic               i_btn_right,
`ifdef WHEEL_EN
    input  logic               i_pulse_wheel_up,
    input  logic               i_pulse_wheel_down,
    output logic [DELTA_W-1:0] o_dz,
    output logic [2:0]         o_ovf,
`else
    output logic [1:0]         o_ovf,
`endif
    output logic               o_report_valid,
    input  logic               i_report_ready,
    output logic [DELTA_W-1:0] o_dx,
    output logic [DELTA_W-1:0] o_dy,
    output logic [1:0]         o_buttons
);

`ifdef WHEEL_EN
    localparam int unsigned AXES = 3;
`else
    localparam int unsigned AXES = 2;
`endif

    typedef logic signed [DELTA_W:0] ext_t;
    localparam ext_t STEP_E  = ext_t'(STEP);
    localparam ext_t SAT_MAX = ext_t'((2 ** (DELTA_W - 1)) - 1);
    localparam ext_t SAT_MIN = ext_t'(-(2 ** (DELTA_W - 1)));

    typedef enum logic { IDLE, HOLD } state_t;

    state_t                     state, next_state;
    logic   [AXES-1:0]          pos, neg;
    logic   [AXES-1:0]          clip, ovf_sticky, rep_ovf;
    logic   signed [DELTA_W-1:0] acc       [AXES];
    logic   signed [DELTA_W-1:0] acc_sat   [AXES];
    logic   signed [DELTA_W-1:0] acc_start [AXES];
    logic   [DELTA_W-1:0]       rep_delta [AXES];
    ext_t                       delta     [AXES];
    ext_t                       sum       [AXES];
    logic   [1:0]               btns, last_btns, rep_btns;
    logic                       motion, trigger, capture;

    // Axis order: 0 = X (right positive), 1 = Y (up positive), 2 = Z (wheel up positive)
`ifdef WHEEL_EN
    assign pos  = {i_pulse_wheel_up, i_pulse_up, i_pulse_right};
    assign neg  = {i_pulse_wheel_down, i_pulse_down, i_pulse_left};
    assign o_dz = rep_delta[2];
`else
    assign pos  = {i_pulse_up, i_pulse_right};
    assign neg  = {i_pulse_down, i_pulse_left};
`endif
    assign btns      = {i_btn_right, i_btn_left};
    assign o_dx      = rep_delta[0];
    assign o_dy      = rep_delta[1];
    assign o_buttons = rep_btns;
    assign o_ovf     = rep_ovf;

    always_comb begin
        motion = 1'b0;
        clip   = '0;
        for (int unsigned a = 0; a < AXES; a++) begin
            delta[a] = '0;
            if (pos[a] && !neg[a])
                delta[a] = STEP_E;
            else if (neg[a] && !pos[a])
                delta[a] = -STEP_E;
            sum[a] = ext_t'(acc[a]) + delta[a];
            if (sum[a] > SAT_MAX) begin
                acc_sat[a] = SAT_MAX[DELTA_W-1:0];
                clip[a]    = 1'b1;
            end else if (sum[a] < SAT_MIN) begin
                acc_sat[a] = SAT_MIN[DELTA_W-1:0];
                clip[a]    = 1'b1;
            end else begin
                acc_sat[a] = sum[a][DELTA_W-1:0];
            end
            acc_start[a] = delta[a][DELTA_W-1:0];
            if (acc[a] != '0)
                motion = 1'b1;
        end
        trigger = motion || (btns != last_btns);
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: if (trigger) begin
                capture    = 1'b1;
                next_state = HOLD;
            end
            HOLD: if (i_report_ready)
                next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign o_report_valid = (state == HOLD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            ovf_sticky <= '0;
            rep_ovf    <= '0;
            last_btns  <= '0;
            rep_btns   <= '0;
            for (int unsigned a = 0; a < AXES; a++) begin
                acc[a]       <= '0;
                rep_delta[a] <= '0;
            end
        end else begin
            state <= next_state;
            // On capture the accumulator restarts from this cycle's step so no pulse is lost
            if (capture) begin
                rep_ovf    <= ovf_sticky;
                rep_btns   <= btns;
                last_btns  <= btns;
                ovf_sticky <= '0;
                for (int unsigned a = 0; a < AXES; a++) begin
                    rep_delta[a] <= acc[a];
                    acc[a]       <= acc_start[a];
                end
            end else begin
                ovf_sticky <= ovf_sticky | clip;
                for (int unsigned a = 0; a < AXES; a++)
                    acc[a] <= acc_sat[a];
            end
        end
    end

endmodule

// File: tb/tb_mouse_move_accum.sv
// Directed scoreboard bench for mouse_move_accum; reports captured on handshakes
// are compared in order against expectations queued alongside the stimulus.
module tb_mouse_move_accum;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, up, down, left, right, btn_l, btn_r, ready, valid;
    logic [W-1:0] dx, dy;
    logic [1:0]   buttons;
    logic [7:0]   dz_obs;
    logic [2:0]   ovf_obs;
`ifdef WHEEL_EN
    logic         wu, wd;
    logic [W-1:0] dz;
    logic [2:0]   ovf;
    assign dz_obs  = dz;
    assign ovf_obs = ovf;
`else
    logic [1:0]   ovf;
    assign dz_obs  = 8'h00;
    assign ovf_obs = {1'b0, ovf};
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    mouse_move_accum #(.DELTA_W(W), .STEP(1)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_pulse_up    (up),
        .i_pulse_down  (down),
        .i_pulse_left  (left),
        .i_pulse_right (right),
        .i_btn_left    (btn_l),
        .i_btn_right   (btn_r),
`ifdef WHEEL_EN
        .i_pulse_wheel_up   (wu),
        .i_pulse_wheel_down (wd),
        .o_dz               (dz),
`endif
        .o_ovf          (ovf),
        .o_report_valid (valid),
        .i_report_ready (ready),
        .o_dx           (dx),
        .o_dy           (dy),
        .o_buttons      (buttons)
    );

    function automatic logic [31:0] pack(input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] z, input logic [1:0] b,
                                         input logic [2:0] o);
        return {3'b000, x, y, z, b, o};
    endfunction

    // Accepted reports: valid & ready seen mid-cycle means the DUT takes it on the next edge
    always @(negedge clk)
        if (!reset && valid && ready)
            got_q.push_back(pack(dx, dy, dz_obs, buttons, ovf_obs));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 100) begin
            cyc();
            n++;
        end
        repeat (8) cyc();
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n;
        reset = 1'b1; ready = 1'b0;
        up = 0; down = 0; left = 0; right = 0; btn_l = 0; btn_r = 0;
`ifdef WHEEL_EN
        wu = 0; wd = 0;
`endif
        repeat (3) cyc();
        check("rst_valid", valid, 0);
        check("rst_dx", dx, 0);
        check("rst_dy", dy, 0);
        check("rst_buttons", buttons, 0);
        check("rst_ovf", ovf_obs, 0);
        reset = 1'b0;
        cyc();

        // Three spaced right steps, two-cycle latency to valid
        ready = 1'b1;
        right = 1'b1;
        cyc();
        right = 1'b0;
        check("t1_lat1", valid, 0);
        cyc();
        check("t1_lat2", valid, 1);
        repeat (3) exp_q.push_back(pack(8'd1, 8'd0, 8'd0, 2'b00, 3'b000));
        repeat (5) cyc();
        right = 1'b1; cyc(); right = 1'b0;
        repeat (5) cyc();
        right = 1'b1; cyc(); right = 1'b0;
        drain("t1");

        // 200 up steps with sink stalled: first report holds dy=1, rest saturates
        ready = 1'b0;
        up = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (i == 100) check("t2_hold_mid", dy, 1);
        end
        up = 1'b0;
        check("t2_hold_valid", valid, 1);
        check("t2_hold_dy", dy, 1);
        exp_q.push_back(pack(8'd0, 8'd1, 8'd0, 2'b00, 3'b000));
        exp_q.push_back(pack(8'd0, 8'd127, 8'd0, 2'b00, 3'b010));
        ready = 1'b1;
        drain("t2");

        // Opposing pulses cancel
        right = 1'b1; left = 1'b1;
        cyc();
        right = 1'b0; left = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            cyc();
            seen |= valid;
        end
        check("t3_no_valid", seen, 0);
        drain("t3");

        // Button press and release each give exactly one zero-motion report
        btn_l = 1'b1;
        exp_q.push_back(pack(8'd0, 8'd0, 8'd0, 2'b01, 3'b000));
        drain("t4");
        btn_l = 1'b0;
        exp_q.push_back(pack(8'd0, 8'd0, 8'd0, 2'b00, 3'b000));
        drain("t4_rel");

        // Second step lands on the capture edge and rolls into the next report
        right = 1'b1;
        cyc();
        cyc();
        right = 1'b0;
        repeat (2) exp_q.push_back(pack(8'd1, 8'd0, 8'd0, 2'b00, 3'b000));
        drain("t5");
        left = 1'b1; down = 1'b1;
        cyc();
        left = 1'b0; down = 1'b0;
        exp_q.push_back(pack(8'hFF, 8'hFF, 8'd0, 2'b00, 3'b000));
        drain("t5_neg");

`ifdef WHEEL_EN
        ready = 1'b0;
        right = 1'b1; cyc(); right = 1'b0;
        repeat (3) cyc();
        wd = 1'b1; cyc(); wd = 1'b0;
        cyc();
        wd = 1'b1; cyc(); wd = 1'b0;
        exp_q.push_back(pack(8'd1, 8'd0, 8'd0, 2'b00, 3'b000));
        exp_q.push_back(pack(8'd0, 8'd0, 8'hFE, 2'b00, 3'b000));
        ready = 1'b1;
        drain("tw");
`endif

        // Reset while a report is held drops it
        ready = 1'b0;
        right = 1'b1; cyc(); right = 1'b0;
        n = 0;
        while (!valid && n < 20) begin
            cyc();
            n++;
        end
        check("t6_valid", valid, 1);
        reset = 1'b1;
        cyc();
        check("t6_valid0", valid, 0);
        check("t6_dx", dx, 0);
        check("t6_dy", dy, 0);
        check("t6_buttons", buttons, 0);
        check("t6_ovf", ovf_obs, 0);
        reset = 1'b0;
        ready = 1'b1;
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
